// File: rtl/ramwriter_pkg.sv
// Shared controller state and opcode codes used by the RAM store path.
package ramwriter_pkg;

    typedef enum logic [3:0] {
        OPCFT = 4'd0,
        OPLFT = 4'd1,
        ADWR  = 4'd2,
        EXEWR = 4'd3
    } cs_e;

    localparam logic [7:0] PUSH   = 8'h10;
    localparam logic [7:0] MOVAR  = 8'h20;
    localparam logic [7:0] MOVAR4 = 8'h21;
    localparam logic [7:0] MOVAR1 = 8'h22;

endpackage

// File: rtl/ramwriter_if.sv
// Controller-to-store-path bundle: sequencing inputs plus the registered RAM write port.
interface ramwriter_if #(
    parameter int AW = 16,
    parameter int NB = 8
);
    logic [3:0]      cs;
    logic [7:0]      opc;
    logic [AW-1:0]   addr;
    logic [8*NB-1:0] d;
    logic            kp;
    logic [AW-1:0]   wa;
    logic [7:0]      wd;
    logic            we;

    modport master (output cs, opc, addr, d, input kp, wa, wd, we);
    modport slave  (input cs, opc, addr, d, output kp, wa, wd, we);
endinterface

// File: rtl/ramwriter_bsel.sv
// Byte selector for the store path; RAMWRITER_BSWAP_EN selects MSB-first emission order.
module ramwriter_bsel #(
    parameter int NB = 8
) (
    input  logic [8*NB-1:0] wbuf,
    input  logic [2:0]      cnt,
    input  logic [2:0]      tim,
    output logic [7:0]      wd_next
);
    logic [2:0] sel;

`ifdef RAMWRITER_BSWAP_EN
    // Highest byte of the selected width goes to the base address.
    always_comb begin
        sel     = tim - cnt;
        wd_next = wbuf[8*sel +: 8];
    end
`else
    wire unused_tim = ^tim;

    always_comb begin
        sel     = cnt;
        wd_next = wbuf[8*sel +: 8];
    end
`endif

endmodule

// File: rtl/ramwriter.sv
// Serializes a 64-bit store value into byte RAM, one byte per EXEWR edge.
module ramwriter
    import ramwriter_pkg::*;
#(
    parameter int AW = 16,
    parameter int NB = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    ramwriter_if.slave bus
);
    logic [AW-1:0]   ptr;
    logic [2:0]      cnt;
    logic [2:0]      tim;
    logic [8*NB-1:0] wbuf;
    logic [7:0]      wd_next;

    ramwriter_bsel #(.NB(NB)) u_bsel (
        .wbuf    (wbuf),
        .cnt     (cnt),
        .tim     (tim),
        .wd_next (wd_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.kp <= 1'b0;
            bus.we <= 1'b0;
            bus.wa <= '0;
            bus.wd <= '0;
            ptr    <= '0;
            cnt    <= '0;
            tim    <= '0;
            wbuf   <= '0;
        end else begin
            case (bus.cs)
                OPLFT: begin
                    bus.we <= 1'b0;
                    case (bus.opc)
                        PUSH, MOVAR: begin tim <= 3'd7; bus.kp <= 1'b1; end
                        MOVAR4:      begin tim <= 3'd3; bus.kp <= 1'b1; end
                        MOVAR1:      begin tim <= 3'd0; bus.kp <= 1'b1; end
                        default:     begin tim <= 3'd0; bus.kp <= 1'b0; end
                    endcase
                end
                ADWR: begin
                    ptr    <= bus.addr;
                    wbuf   <= bus.d;
                    cnt    <= '0;
                    bus.we <= 1'b0;
                end
                EXEWR: begin
                    if (bus.kp) begin
                        bus.wa <= ptr;
                        bus.wd <= wd_next;
                        bus.we <= 1'b1;
                        ptr    <= ptr + AW'(1);
                        cnt    <= cnt + 3'd1;
                        // kp drops with the last launch so the controller exits while we is still high.
                        if (cnt == tim) bus.kp <= 1'b0;
                    end else begin
                        bus.we <= 1'b0;
                    end
                end
                default: bus.we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ramwriter.sv
// Randomized bench for ramwriter with a write-queue reference model and literal RAM checks.
module tb_ramwriter;
    import ramwriter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ramwriter_if #(.AW(16), .NB(8)) bus ();

    ramwriter #(.AW(16), .NB(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int wecount = 0;
    bit run = 1'b0;
    logic [7:0] ram [0:65535];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int nbytes(logic [7:0] o);
        case (o)
            PUSH, MOVAR: return 8;
            MOVAR4:      return 4;
            MOVAR1:      return 1;
            default:     return 0;
        endcase
    endfunction

    // Reference model: ADWR expands the store into a queue of (address, byte) writes.
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  b;
    } wr_t;

    wr_t         q[$];
    int          nb_m = 0;
    logic        kp_m = 1'b0;
    logic        we_m = 1'b0;
    logic [15:0] wa_m = '0;
    logic [7:0]  wd_m = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            nb_m = 0;
            kp_m = 1'b0;
            we_m = 1'b0;
            wa_m = '0;
            wd_m = '0;
        end else begin
            we_m = 1'b0;
            case (bus.cs)
                OPLFT: begin
                    nb_m = nbytes(bus.opc);
                    kp_m = (nb_m > 0);
                end
                ADWR: begin
                    q.delete();
                    if (kp_m) begin
                        for (int i = 0; i < nb_m; i++) begin
                            int bi;
                            logic [63:0] sh;
                            wr_t w;
`ifdef RAMWRITER_BSWAP_EN
                            bi = nb_m - 1 - i;
`else
                            bi = i;
`endif
                            sh  = bus.d >> (8 * bi);
                            w.a = bus.addr + 16'(i);
                            w.b = sh[7:0];
                            q.push_back(w);
                        end
                    end
                end
                EXEWR: begin
                    if (kp_m && q.size() > 0) begin
                        wr_t w;
                        w    = q.pop_front();
                        wa_m = w.a;
                        wd_m = w.b;
                        we_m = 1'b1;
                        kp_m = (q.size() != 0);
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) if (bus.we) ram[bus.wa] <= bus.wd;

    always @(negedge clk) begin
        if (run) begin
            chk("kp", {63'd0, bus.kp}, {63'd0, kp_m});
            chk("we", {63'd0, bus.we}, {63'd0, we_m});
            if (we_m) begin
                chk("wa", {48'd0, bus.wa}, {48'd0, wa_m});
                chk("wd", {56'd0, bus.wd}, {56'd0, wd_m});
            end
            if (bus.we) wecount++;
        end
    end

    task automatic cyc(input logic [3:0] c, input logic [7:0] o, input logic [15:0] a, input logic [63:0] dd);
        bus.cs   = c;
        bus.opc  = o;
        bus.addr = a;
        bus.d    = dd;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [3:0] other_cs();
        if ($urandom_range(0, 1) == 0) return OPCFT;
        return 4'($urandom_range(4, 15));
    endfunction

    task automatic xfer(input logic [7:0] op, input logic [15:0] a, input logic [63:0] dd,
                        input int gap_at, input int gap_len);
        int n;
        cyc(OPLFT, op, 16'($urandom), {$urandom, $urandom});
        cyc(ADWR, op, a, dd);
        n = nbytes(op);
        if (n == 0) n = 2;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) cyc(other_cs(), op, 16'($urandom), {$urandom, $urandom});
            cyc(EXEWR, op, 16'($urandom), {$urandom, $urandom});
        end
        cyc(OPCFT, op, 16'($urandom), {$urandom, $urandom});
    endtask

    initial begin
        int w0;
        logic [7:0] e;
        bus.cs = OPCFT; bus.opc = '0; bus.addr = '0; bus.d = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #2;
        chk("rst_kp", {63'd0, bus.kp}, 64'd0);
        chk("rst_we", {63'd0, bus.we}, 64'd0);
        chk("rst_wa", {48'd0, bus.wa}, 64'd0);
        chk("rst_wd", {56'd0, bus.wd}, 64'd0);
        rst_n = 1'b1;
        run = 1'b1;
        cyc(OPCFT, 8'h00, 16'h0, 64'h0);

        // MOVAR, 8 bytes
        w0 = wecount;
        xfer(MOVAR, 16'h0100, 64'h8877665544332211, -1, 0);
        chk("t1_pulses", 64'(wecount - w0), 64'd8);
        for (int i = 0; i < 8; i++) begin
`ifdef RAMWRITER_BSWAP_EN
            e = 8'(8'h11 * (8 - i));
`else
            e = 8'(8'h11 * (i + 1));
`endif
            chk("t1_ram", {56'd0, ram[16'h0100 + 16'(i)]}, {56'd0, e});
        end

        // MOVAR4
        w0 = wecount;
        xfer(MOVAR4, 16'h0200, 64'h12345678DDCCBBAA, -1, 0);
        chk("t2_pulses", 64'(wecount - w0), 64'd4);
`ifdef RAMWRITER_BSWAP_EN
        chk("t2_ram0", {56'd0, ram[16'h0200]}, 64'hDD);
        chk("t2_ram3", {56'd0, ram[16'h0203]}, 64'hAA);
`else
        chk("t2_ram0", {56'd0, ram[16'h0200]}, 64'hAA);
        chk("t2_ram3", {56'd0, ram[16'h0203]}, 64'hDD);
`endif

        // MOVAR1 and an unknown opcode
        w0 = wecount;
        xfer(MOVAR1, 16'h0010, 64'h000000000000005A, -1, 0);
        chk("t3_pulses", 64'(wecount - w0), 64'd1);
        chk("t3_ram", {56'd0, ram[16'h0010]}, 64'h5A);
        w0 = wecount;
        cyc(OPLFT, 8'hFF, 16'h0, 64'h0);
        chk("t3_unk_kp", {63'd0, bus.kp}, 64'd0);
        cyc(ADWR, 8'hFF, 16'h0020, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) cyc(EXEWR, 8'hFF, 16'h0, 64'h0);
        chk("t3_unk_pulses", 64'(wecount - w0), 64'd0);

        // PUSH across the top of the address space
        xfer(PUSH, 16'hFFFE, 64'h0807060504030201, -1, 0);
`ifdef RAMWRITER_BSWAP_EN
        chk("t4_fffe", {56'd0, ram[16'hFFFE]}, 64'h08);
        chk("t4_0000", {56'd0, ram[16'h0000]}, 64'h06);
        chk("t4_0005", {56'd0, ram[16'h0005]}, 64'h01);
`else
        chk("t4_fffe", {56'd0, ram[16'hFFFE]}, 64'h01);
        chk("t4_0000", {56'd0, ram[16'h0000]}, 64'h03);
        chk("t4_0005", {56'd0, ram[16'h0005]}, 64'h08);
`endif

        // MOVAR with a 2-cycle excursion out of EXEWR after 3 bytes
        w0 = wecount;
        xfer(MOVAR, 16'h0400, 64'hF0E1D2C3B4A59687, 3, 2);
        chk("t5_pulses", 64'(wecount - w0), 64'd8);
`ifdef RAMWRITER_BSWAP_EN
        chk("t5_ram3", {56'd0, ram[16'h0403]}, 64'hC3);
        chk("t5_ram7", {56'd0, ram[16'h0407]}, 64'h87);
`else
        chk("t5_ram3", {56'd0, ram[16'h0403]}, 64'hB4);
        chk("t5_ram7", {56'd0, ram[16'h0407]}, 64'hF0);
`endif

        // Asynchronous reset in the middle of byte 4
        cyc(OPLFT, MOVAR, 16'h0, 64'h0);
        cyc(ADWR, MOVAR, 16'h0300, 64'h1122334455667788);
        repeat (3) cyc(EXEWR, MOVAR, 16'h0, 64'h0);
        bus.cs = EXEWR;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_kp", {63'd0, bus.kp}, 64'd0);
        chk("t6_we", {63'd0, bus.we}, 64'd0);
        chk("t6_wa", {48'd0, bus.wa}, 64'd0);
        chk("t6_wd", {56'd0, bus.wd}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        w0 = wecount;
        repeat (4) cyc(EXEWR, MOVAR, 16'h0, 64'h0);
        cyc(OPCFT, 8'h00, 16'h0, 64'h0);
        chk("t6_no_writes", 64'(wecount - w0), 64'd0);

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            logic [7:0] op;
            int sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0: op = PUSH;
                1: op = MOVAR;
                2: op = MOVAR4;
                3: op = MOVAR1;
                default: begin
                    op = 8'($urandom);
                    while (nbytes(op) != 0) op = 8'($urandom);
                end
            endcase
            xfer(op, 16'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 9), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) cyc(EXEWR, op, 16'($urandom), 64'h0);
        end

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramwriter.md
Name: ramwriter

Overview:
Store-side partner of the 64-bit RAM byte reader. It serializes a 64-bit register value into the 8-bit data RAM, one byte per cycle, at consecutive addresses. Transfers are sequenced by the CPU control state `cs` and the decoded opcode `opc`. Used by PUSH, MOVAR (8 bytes), MOVAR4 (4 bytes) and MOVAR1 (1 byte). `kp` holds the controller in the write-execute state until the last byte has issued.

Parameters:
- AW, 16: RAM address width.
- NB, 8: maximum bytes per transfer; sets `d` width to 8*NB and `cnt`/`tim` width to 3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cs  in  4  CPU control state; encodings come from the shared state header.
- opc  in  8  current opcode; encodings come from the shared state header.
- addr  in  AW  store base address, sampled in `ADWR`.
- d  in  8*NB  store data, sampled in `ADWR`.
- kp  out  1  keep/busy; high while bytes remain to be written.
- wa  out  AW  RAM write address, registered.
- wd  out  8  RAM write data, registered.
- we  out  1  RAM write enable, registered; RAM writes `wd` to `wa` on the edge where `we` is 1.

Behaviour:
- Reset (`rst_n` = 0, asynchronous): `kp`, `we` = 0; `wa`, `wd` = 0; internal `ptr`, `cnt`, `tim`, `wbuf` = 0.
- `cs` == `OPLFT`, opcode decode; sets `tim` = byte count − 1:
  - PUSH → `tim` = 7, `kp` = 1.
  - MOVAR → `tim` = 7, `kp` = 1.
  - MOVAR4 → `tim` = 3, `kp` = 1.
  - MOVAR1 → `tim` = 0, `kp` = 1.
  - any other opcode → `tim` = 0, `kp` = 0.
  - `we` = 0.
- `cs` == `ADWR`: `ptr` <= `addr`; `wbuf` <= `d`; `cnt` <= 0; `we` <= 0; `kp` unchanged.
- `cs` == `EXEWR` and `kp` = 1, each edge:
  - `wa` <= `ptr`; `wd` <= `wbuf[8*cnt +: 8]` (little-endian: byte 0 at base address); `we` <= 1.
  - `ptr` <= `ptr` + 1, modulo 2^AW; 16'hFFFF wraps to 16'h0000.
  - `cnt` <= `cnt` + 1.
  - If `cnt` == `tim`: `kp` <= 0.
- `cs` == `EXEWR` and `kp` = 0: `we` <= 0; no other change.
- Any other `cs` value: `we` <= 0; all other state held.
- Timing: a transfer of N bytes needs N `EXEWR` edges. Write k is visible on `wa`/`wd`/`we` in the cycle after edge k. `kp` falls on the same edge that launches the last write, so the controller leaves `EXEWR` one cycle later while the final `we` pulse is still present.
- Mid-transfer, `cs` leaves `EXEWR`: transfer freezes (`cnt`, `ptr`, `kp` held, `we` = 0) and resumes when `EXEWR` returns.
- `OPLFT` while `kp` = 1: new decode overrides (abort and reload `tim`); `cnt` is not cleared until `ADWR`.
- `ADWR` while `kp` = 1: restarts at the new base with fresh data.
- `OPCFT`: treated as "other"; `we` <= 0.
- Reset asserted mid-transfer: immediate return to reset values; no further `we`.

Optional Feature:
`RAMWRITER_BSWAP_EN` (compile-time macro).
- Defined: bytes are emitted MSB-first within the selected width; `wd` <= `wbuf[8*(tim−cnt) +: 8]`. MOVAR4 writes `d[31:24]` at base.
- Undefined: little-endian order as above.
- Address sequence is ascending in both cases.

Decomposition:
- Shared state header (existing): `cs` codes `OPCFT`, `OPLFT`, `ADWR`, `EXEWR`; opcodes `PUSH`, `MOVAR`, `MOVAR4`, `MOVAR1`. The new codes `ADWR`/`EXEWR` are added there, distinct from existing codes.
- One natural sub-module: `ramwriter_bsel`, a combinational byte selector taking `wbuf`, `cnt`, `tim` and returning 8-bit `wd_next`; this is where the `RAMWRITER_BSWAP_EN` ordering lives.
- The top block holds the counter, pointer and the `kp`/`we` registers.

Test Plan:
1. MOVAR, `addr` = 16'h0100, `d` = 64'h8877665544332211, 8 `EXEWR` cycles → writes 11,22,…,88 at 0100..0107; `kp` falls on the 8th edge; `we` pulses exactly 8 times.
2. MOVAR4, `addr` = 16'h0200, `d` = 64'hxxxxxxxxDDCCBBAA → 4 writes AA,BB,CC,DD at 0200..0203; with `RAMWRITER_BSWAP_EN`: DD,CC,BB,AA.
3. MOVAR1 at 16'h0010, `d[7:0]` = 8'h5A → single write 5A @0010; `kp` high for 1 `EXEWR` edge only. Unknown opcode 8'hFF → `kp` = 0, no `we`.
4. PUSH at `addr` = 16'hFFFE → writes at FFFE, FFFF, 0000..0005 (wrap verified).
5. MOVAR, `cs` leaves `EXEWR` after 3 bytes for 2 cycles, then returns → `we` = 0 during the gap; remaining 5 bytes continue at base+3; no byte duplicated or skipped.
6. `rst_n` pulsed low asynchronously mid-edge-gap during byte 4 of MOVAR → `kp`, `we`, `wa`, `wd` go to 0 immediately; no further writes after release until a new `OPLFT`/`ADWR`.
